// File: rtl/cp0_regfile_if.sv
// mtc0/mfc0 access bus between the M stage and the CP0 register file.
interface cp0_regfile_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output we_i, waddr_i, raddr_i, wdata_i, input rdata_o);
  modport slave  (input we_i, waddr_i, raddr_i, wdata_i, output rdata_o);
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: exception commit, eret, mtc0/mfc0,
// Count/Compare timer and hardware interrupt sampling into Cause.IP.
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  cp0_regfile_if.slave bus,
  input  logic [5:0]  ext_int,
  input  logic [31:0] except_type,
  input  logic [31:0] pcM,
  input  logic        is_in_delayslot,
  input  logic [31:0] badvaddrM,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] ERET_TYPE    = 32'h0000_000e;

  logic        tick;
  logic        exc, eret, wr, match;
  logic        wr_status, wr_cause, wr_epc, wr_count, wr_compare;
  logic        bad_addr_exc;
  logic [4:0]  exc_code;
  logic [31:0] status_n, cause_n, epc_n;

  assign exc          = (except_type != '0) && (except_type != ERET_TYPE);
  assign eret         = (except_type == ERET_TYPE);
  // A committing exception or eret flushes the M-stage mtc0.
  assign wr           = bus.we_i && !exc && !eret;
  assign wr_status    = wr && (bus.waddr_i == 5'd12);
  assign wr_cause     = wr && (bus.waddr_i == 5'd13);
  assign wr_epc       = wr && (bus.waddr_i == 5'd14);
  assign wr_count     = wr && (bus.waddr_i == 5'd9);
  assign wr_compare   = wr && (bus.waddr_i == 5'd11);
  assign match        = (compare_o != '0) && (count_o == compare_o);
  assign bad_addr_exc = exc && ((except_type == 32'h4) || (except_type == 32'h5));
  assign timer_int_o  = cause_o[30];

  always_comb begin
    exc_code = cause_o[6:2];
    case (except_type)
      32'h1:   exc_code = 5'd0;
      32'h4:   exc_code = 5'd4;
      32'h5:   exc_code = 5'd5;
      32'h8:   exc_code = 5'd8;
      32'h9:   exc_code = 5'd9;
      32'ha:   exc_code = 5'd10;
      32'hc:   exc_code = 5'd12;
      default: exc_code = cause_o[6:2];
    endcase
  end

  always_comb begin
    status_n = status_o;
    if (wr_status)
      status_n = (status_o & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK);
    if (exc)
      status_n[1] = 1'b1;
    else if (eret)
      status_n[1] = 1'b0;
  end

  always_comb begin
    cause_n        = cause_o;
    cause_n[15:10] = ext_int;
    if (wr_cause)
      cause_n[9:8] = bus.wdata_i[9:8];
    if (match)
      cause_n[30] = 1'b1;
    // The Compare write clear is applied last so it beats a same-cycle match.
    if (wr_compare)
      cause_n[30] = 1'b0;
    if (exc) begin
      if (!status_o[1])
        cause_n[31] = is_in_delayslot;
      cause_n[6:2] = exc_code;
    end
  end

  always_comb begin
    epc_n = epc_o;
    if (wr_epc)
      epc_n = bus.wdata_i;
    if (exc && !status_o[1])
      epc_n = is_in_delayslot ? (pcM - 32'd4) : pcM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick       <= 1'b0;
      status_o   <= STATUS_RESET;
      cause_o    <= '0;
      epc_o      <= '0;
      badvaddr_o <= '0;
      count_o    <= '0;
      compare_o  <= '0;
    end else begin
      tick     <= ~tick;
      status_o <= status_n;
      cause_o  <= cause_n;
      epc_o    <= epc_n;
      if (bad_addr_exc)
        badvaddr_o <= badvaddrM;
      if (wr_count)
        count_o <= bus.wdata_i;
      else if (tick)
        count_o <= count_o + 32'd1;
      if (wr_compare)
        compare_o <= bus.wdata_i;
    end
  end

  always_comb begin
    case (bus.raddr_i)
      5'd8:    bus.rdata_o = badvaddr_o;
      5'd9:    bus.rdata_o = count_o;
      5'd11:   bus.rdata_o = compare_o;
      5'd12:   bus.rdata_o = status_o;
      5'd13:   bus.rdata_o = cause_o;
      5'd14:   bus.rdata_o = epc_o;
      5'd15:   bus.rdata_o = PRID_VALUE;
      5'd16:   bus.rdata_o = CONFIG_VALUE;
      default: bus.rdata_o = '0;
    endcase
  end

endmodule
